wb_fwd_ctrl: RTL and testbench
==============================

# wb_fwd_ctrl

Operand forwarding and load-use stall controller for the LC-3b pipeline decode/execute boundary. Consumes the two retained writeback entries (slot 0 = most recent, slot 1 = older) together with the in-flight EX and MEM destinations, and selects the freshest value for each source operand. Tracks per-slot valid bits in lockstep with the retained writeback registers. Runs a small FSM that stalls the front end on load-use hazards until memory responds.

## Interface
Parameters:
- WIDTH, 16, datapath width
- CNT_W, 8, width of the saturating stall-cycle counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sr1, sr2  in  3  decode source register numbers
- sr1_use, sr2_use  in  1  source is actually read by the instruction
- rf_sr1, rf_sr2  in  WIDTH  register-file read data
- ex_dr  in  3  EX-stage destination; ex_wr in 1 writes a register; ex_is_load in 1 is a load; ex_val in WIDTH ALU result
- mem_dr  in  3  MEM-stage destination; mem_wr, mem_is_load, mem_resp in 1; mem_val in WIDTH (ALU result, or load data when mem_resp)
- wb_wr  in  1  WB stage writes a register this cycle
- retain_load, retain_clear  in  1  same strobes that drive the retained writeback registers
- wb_sel_0, wb_sel_1  in  3  retained destinations; wb_val_0, wb_val_1 in WIDTH retained values
- flush  in  1  pipeline flush (branch/trap)
- opnd1, opnd2  out  WIDTH  forwarded operands
- stall  out  1  hold PC and IF/ID, inject bubble into EX
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Valid slots: internal v0, v1. On retain_clear: v0=v1=0 (clear wins over load). Else on retain_load: v0<=wb_wr, v1<=v0. Else hold.
- EX hit: ex_wr && !ex_is_load && ex_dr==src. MEM hit: mem_wr && mem_dr==src && (!mem_is_load || mem_resp). WB0 hit: v0 && wb_sel_0==src. WB1 hit: v1 && wb_sel_1==src.
- Operand priority per source: EX > MEM > WB0 > WB1 > regfile. Combinational; srcN_use=0 still yields a value (don't-care) but never causes a stall.
- Hazards (per used source): hz_ex = ex_wr && ex_is_load && ex_dr==src; hz_mem = mem_wr && mem_is_load && !mem_resp && mem_dr==src.
- FSM states RUN, LDWAIT:
  - RUN: stall = hz_ex | hz_mem (either source). If hz_ex or hz_mem -> LDWAIT.
  - LDWAIT: stall = hz_ex | hz_mem (recomputed each cycle; normally hz_mem while load is in MEM). When stall drops (mem_resp with matching mem_dr forwards mem_val) -> RUN.
  - flush in any state: stall=0, next state RUN.
- stall_cnt increments by 1 each cycle stall=1, saturates at 2^CNT_W-1, never wraps.
- R0..R7 all forwardable; no hard-wired zero register.

## Timing
- Reset (async, rst_n low): state=RUN, v0=v1=0, stall_cnt=0. opnd1/opnd2 then equal rf values unless EX/MEM hit; stall follows combinational hazard terms but FSM stays RUN while rst_n low.
- opnd1/2 and stall are same-cycle combinational from inputs and current state/valid bits; zero latency.
- v0/v1 and state update on rising clk; valid bits lag the retain strobes by exactly one edge, matching the retained registers.
- Minimum load-use penalty: 1 stall cycle (load in EX); each cycle mem_resp is low while the load sits in MEM adds 1.
- Simultaneous retain_load and retain_clear: clear wins. Simultaneous flush and hazard: flush wins, stall=0.
- Reset asserted mid-LDWAIT: immediate return to RUN, counter cleared.

## Test plan
- Priority: sr1=3 used; ex_dr=3 ex_val=0x1111; mem_dr=3 mem_val=0x2222; v0 wb_sel_0=3 wb_val_0=0x3333 -> opnd1=0x1111; drop ex_wr -> 0x2222; drop mem_wr -> 0x3333; clear -> rf_sr1.
- Retain tracking: retain_load with wb_wr=1,0 on consecutive edges -> v0=0,v1=1; wb_sel_1=5 wb_val_1=0xBEEF, sr2=5 -> opnd2=0xBEEF; retain_clear -> opnd2=rf_sr2.
- Load-use: ex load dr=2, sr1=2 used -> stall=1, LDWAIT; next cycle mem load dr=2 mem_resp=0 for 2 cycles -> stall=1; mem_resp=1 mem_val=0x00AB -> stall=0, opnd1=0x00AB, RUN; stall_cnt=3.
- Unused source: ex load dr=4, sr2=4 sr2_use=0 -> stall=0.
- Flush in LDWAIT -> stall=0 same cycle, RUN next edge; async rst_n low mid-stall -> stall_cnt=0, state RUN.
- Counter saturation (CNT_W=8): hold hazard 300 cycles -> stall_cnt=255.

Source files
------------

// File: rtl/wb_fwd_ctrl.sv
// Operand forwarding and load-use stall control at the LC-3b decode/execute boundary.
// Picks the freshest value per source (EX > MEM > WB0 > WB1 > regfile) and stalls on unresolved loads.
module wb_fwd_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sr1,
    input  logic [2:0]       sr2,
    input  logic             sr1_use,
    input  logic             sr2_use,
    input  logic [WIDTH-1:0] rf_sr1,
    input  logic [WIDTH-1:0] rf_sr2,
    input  logic [2:0]       ex_dr,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic [WIDTH-1:0] ex_val,
    input  logic [2:0]       mem_dr,
    input  logic             mem_wr,
    input  logic             mem_is_load,
    input  logic             mem_resp,
    input  logic [WIDTH-1:0] mem_val,
    input  logic             wb_wr,
    input  logic             retain_load,
    input  logic             retain_clear,
    input  logic [2:0]       wb_sel_0,
    input  logic [2:0]       wb_sel_1,
    input  logic [WIDTH-1:0] wb_val_0,
    input  logic [WIDTH-1:0] wb_val_1,
    input  logic             flush,
    output logic [WIDTH-1:0] opnd1,
    output logic [WIDTH-1:0] opnd2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        LDWAIT = 1'b1
    } state_t;

    state_t           state_r;
    logic             v0_r;
    logic             v1_r;
    logic [CNT_W-1:0] cnt_r;

    logic ex_hit1_s, mem_hit1_s, wb0_hit1_s, wb1_hit1_s;
    logic ex_hit2_s, mem_hit2_s, wb0_hit2_s, wb1_hit2_s;
    logic hz1_s, hz2_s, hazard_s, stall_s;

    // A load still in EX has no data yet, and a load in MEM only forwards once memory responds.
    assign ex_hit1_s  = ex_wr && !ex_is_load && (ex_dr == sr1);
    assign ex_hit2_s  = ex_wr && !ex_is_load && (ex_dr == sr2);
    assign mem_hit1_s = mem_wr && (mem_dr == sr1) && (!mem_is_load || mem_resp);
    assign mem_hit2_s = mem_wr && (mem_dr == sr2) && (!mem_is_load || mem_resp);
    assign wb0_hit1_s = v0_r && (wb_sel_0 == sr1);
    assign wb0_hit2_s = v0_r && (wb_sel_0 == sr2);
    assign wb1_hit1_s = v1_r && (wb_sel_1 == sr1);
    assign wb1_hit2_s = v1_r && (wb_sel_1 == sr2);

    assign hz1_s = sr1_use && ex_wr && ex_is_load && (ex_dr == sr1)
                 || sr1_use && mem_wr && mem_is_load && !mem_resp && (mem_dr == sr1);
    assign hz2_s = sr2_use && ex_wr && ex_is_load && (ex_dr == sr2)
                 || sr2_use && mem_wr && mem_is_load && !mem_resp && (mem_dr == sr2);
    assign hazard_s = hz1_s || hz2_s;
    assign stall_s  = hazard_s && !flush;

    // Operand 1 priority mux.
    always_comb begin
        opnd1 = rf_sr1;
        if (ex_hit1_s) begin
            opnd1 = ex_val;
        end else if (mem_hit1_s) begin
            opnd1 = mem_val;
        end else if (wb0_hit1_s) begin
            opnd1 = wb_val_0;
        end else if (wb1_hit1_s) begin
            opnd1 = wb_val_1;
        end else begin
            opnd1 = rf_sr1;
        end
    end

    // Operand 2 priority mux.
    always_comb begin
        opnd2 = rf_sr2;
        if (ex_hit2_s) begin
            opnd2 = ex_val;
        end else if (mem_hit2_s) begin
            opnd2 = mem_val;
        end else if (wb0_hit2_s) begin
            opnd2 = wb_val_0;
        end else if (wb1_hit2_s) begin
            opnd2 = wb_val_1;
        end else begin
            opnd2 = rf_sr2;
        end
    end

    assign stall     = stall_s;
    assign stall_cnt = cnt_r;

    // Slot valid bits shadow the retained writeback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else if (retain_clear) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else if (retain_load) begin
            v0_r <= wb_wr;
            v1_r <= v0_r;
        end else begin
            v0_r <= v0_r;
            v1_r <= v1_r;
        end
    end

    // Load-use FSM; flush always returns to RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RUN;
        end else if (flush) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN:     state_r <= hazard_s ? LDWAIT : RUN;
                LDWAIT:  state_r <= hazard_s ? LDWAIT : RUN;
                default: state_r <= RUN;
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_wb_fwd_ctrl.sv
// Self-checking bench for wb_fwd_ctrl: directed scenarios, then randomized traffic
// compared with a behavioural model of forwarding priority, slot history and stall counting.
module tb_wb_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sr1, sr2, ex_dr, mem_dr, wb_sel_0, wb_sel_1;
    logic        sr1_use, sr2_use, ex_wr, ex_is_load, mem_wr, mem_is_load, mem_resp;
    logic        wb_wr, retain_load, retain_clear, flush;
    logic [15:0] rf_sr1, rf_sr2, ex_val, mem_val, wb_val_0, wb_val_1;
    logic [15:0] opnd1, opnd2;
    logic        stall;
    logic [7:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: validity history of the two retained slots, stall count.
    logic mv[0:1];
    int   mcnt;

    always #5 clk = ~clk;

    wb_fwd_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .sr1(sr1), .sr2(sr2), .sr1_use(sr1_use), .sr2_use(sr2_use),
        .rf_sr1(rf_sr1), .rf_sr2(rf_sr2),
        .ex_dr(ex_dr), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_val(ex_val),
        .mem_dr(mem_dr), .mem_wr(mem_wr), .mem_is_load(mem_is_load),
        .mem_resp(mem_resp), .mem_val(mem_val),
        .wb_wr(wb_wr), .retain_load(retain_load), .retain_clear(retain_clear),
        .wb_sel_0(wb_sel_0), .wb_sel_1(wb_sel_1), .wb_val_0(wb_val_0), .wb_val_1(wb_val_1),
        .flush(flush),
        .opnd1(opnd1), .opnd2(opnd2), .stall(stall), .stall_cnt(stall_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        sr1 = 3'd0; sr2 = 3'd0; sr1_use = 1'b0; sr2_use = 1'b0;
        rf_sr1 = 16'h0AAA; rf_sr2 = 16'h0BBB;
        ex_dr = 3'd0; ex_wr = 1'b0; ex_is_load = 1'b0; ex_val = 16'h0000;
        mem_dr = 3'd0; mem_wr = 1'b0; mem_is_load = 1'b0; mem_resp = 1'b0; mem_val = 16'h0000;
        wb_wr = 1'b0; retain_load = 1'b0; retain_clear = 1'b0;
        wb_sel_0 = 3'd0; wb_sel_1 = 3'd0; wb_val_0 = 16'h0000; wb_val_1 = 16'h0000;
        flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Freshest producer of register s: younger pipeline stages shadow older ones.
    function automatic logic [15:0] model_opnd(input logic [2:0] s, input logic [15:0] rf);
        logic [15:0] r;
        r = rf;
        if (mv[1] && wb_sel_1 == s) r = wb_val_1;
        if (mv[0] && wb_sel_0 == s) r = wb_val_0;
        if (mem_wr && mem_dr == s && (!mem_is_load || mem_resp)) r = mem_val;
        if (ex_wr && !ex_is_load && ex_dr == s) r = ex_val;
        return r;
    endfunction

    // A used source whose producer is a load that has not yet delivered data must wait.
    function automatic logic model_wait(input logic [2:0] s, input logic u);
        logic pending;
        pending = (ex_wr && ex_is_load && ex_dr == s)
               || (mem_wr && mem_is_load && !mem_resp && mem_dr == s);
        return u && pending;
    endfunction

    initial begin
        logic exp_stall;
        set_idle();
        rst_n = 1'b0;
        #2;
        check_val("reset_cnt", {24'd0, stall_cnt}, 32'd0);
        check_val("reset_stall", {31'd0, stall}, 32'd0);
        check_val("reset_opnd1", {16'd0, opnd1}, 32'h0AAA);
        @(negedge clk);
        rst_n = 1'b1;

        // Priority EX > MEM > WB0 > regfile
        wb_wr = 1'b1; retain_load = 1'b1;
        @(negedge clk);
        wb_wr = 1'b0; retain_load = 1'b0;
        sr1 = 3'd3; sr1_use = 1'b1;
        ex_wr = 1'b1; ex_dr = 3'd3; ex_val = 16'h1111;
        mem_wr = 1'b1; mem_dr = 3'd3; mem_val = 16'h2222;
        wb_sel_0 = 3'd3; wb_val_0 = 16'h3333;
        #2 check_val("prio_ex", {16'd0, opnd1}, 32'h1111);
        ex_wr = 1'b0;
        #1 check_val("prio_mem", {16'd0, opnd1}, 32'h2222);
        mem_wr = 1'b0;
        #1 check_val("prio_wb0", {16'd0, opnd1}, 32'h3333);
        retain_clear = 1'b1;
        @(negedge clk);
        retain_clear = 1'b0;
        #2 check_val("prio_rf", {16'd0, opnd1}, 32'h0AAA);

        // Retain tracking: two loads with wb_wr=1 then 0 leaves only slot 1 valid
        set_idle();
        wb_wr = 1'b1; retain_load = 1'b1;
        @(negedge clk);
        wb_wr = 1'b0;
        @(negedge clk);
        retain_load = 1'b0;
        sr2 = 3'd5; sr2_use = 1'b1;
        wb_sel_0 = 3'd5; wb_val_0 = 16'h1234;
        wb_sel_1 = 3'd5; wb_val_1 = 16'hBEEF;
        #2 check_val("retain_wb1", {16'd0, opnd2}, 32'hBEEF);
        retain_clear = 1'b1; retain_load = 1'b1;
        @(negedge clk);
        retain_clear = 1'b0; retain_load = 1'b0;
        #2 check_val("retain_clear", {16'd0, opnd2}, 32'h0BBB);

        // Load-use: 1 cycle in EX, 2 waiting cycles in MEM, then response forwards
        set_idle();
        do_reset();
        sr1 = 3'd2; sr1_use = 1'b1;
        ex_wr = 1'b1; ex_is_load = 1'b1; ex_dr = 3'd2;
        #2 check_val("lu_ex_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        ex_wr = 1'b0; ex_is_load = 1'b0;
        mem_wr = 1'b1; mem_is_load = 1'b1; mem_dr = 3'd2; mem_resp = 1'b0;
        #2 check_val("lu_mem_stall1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #2 check_val("lu_mem_stall2", {31'd0, stall}, 32'd1);
        @(negedge clk);
        mem_resp = 1'b1; mem_val = 16'h00AB;
        #2 check_val("lu_resp_stall", {31'd0, stall}, 32'd0);
        check_val("lu_resp_opnd", {16'd0, opnd1}, 32'h00AB);
        check_val("lu_cnt", {24'd0, stall_cnt}, 32'd3);

        // Unused source never stalls
        set_idle();
        sr2 = 3'd4; sr2_use = 1'b0;
        ex_wr = 1'b1; ex_is_load = 1'b1; ex_dr = 3'd4;
        #1 check_val("unused_stall", {31'd0, stall}, 32'd0);

        // Flush overrides a hazard; hazard reasserts once flush drops
        sr2_use = 1'b1;
        #1 check_val("flush_pre", {31'd0, stall}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1 check_val("flush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1 check_val("flush_after", {31'd0, stall}, 32'd1);

        // Async reset mid-stall clears the counter immediately
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_val("rst_mid_cnt", {24'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 300 stalled cycles
        repeat (300) @(negedge clk);
        #1 check_val("sat_cnt", {24'd0, stall_cnt}, 32'd255);

        // Randomized traffic against the model
        set_idle();
        do_reset();
        mv[0] = 1'b0; mv[1] = 1'b0; mcnt = 0;
        for (int i = 0; i < 400; i++) begin
            sr1 = 3'($urandom_range(0, 3)); sr2 = 3'($urandom_range(0, 3));
            sr1_use = 1'($urandom); sr2_use = 1'($urandom);
            rf_sr1 = 16'($urandom); rf_sr2 = 16'($urandom);
            ex_dr = 3'($urandom_range(0, 3)); ex_wr = 1'($urandom);
            ex_is_load = ($urandom_range(0, 3) == 0); ex_val = 16'($urandom);
            mem_dr = 3'($urandom_range(0, 3)); mem_wr = 1'($urandom);
            mem_is_load = 1'($urandom); mem_resp = 1'($urandom); mem_val = 16'($urandom);
            wb_wr = 1'($urandom); retain_load = 1'($urandom);
            retain_clear = ($urandom_range(0, 7) == 0);
            wb_sel_0 = 3'($urandom_range(0, 3)); wb_sel_1 = 3'($urandom_range(0, 3));
            wb_val_0 = 16'($urandom); wb_val_1 = 16'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            #2;
            exp_stall = !flush && (model_wait(sr1, sr1_use) || model_wait(sr2, sr2_use));
            check_val("rnd_opnd1", {16'd0, opnd1}, {16'd0, model_opnd(sr1, rf_sr1)});
            check_val("rnd_opnd2", {16'd0, opnd2}, {16'd0, model_opnd(sr2, rf_sr2)});
            check_val("rnd_stall", {31'd0, stall}, {31'd0, exp_stall});
            check_val("rnd_cnt", {24'd0, stall_cnt}, 32'(mcnt));
            @(posedge clk);
            if (exp_stall && mcnt < 255) mcnt++;
            if (retain_clear) begin
                mv[0] = 1'b0; mv[1] = 1'b0;
            end else if (retain_load) begin
                mv[1] = mv[0]; mv[0] = wb_wr;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
